// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   RegBus          - datapath width (32)
//   Assert/Asserted - active-level constants for control signals
//   lsu_state_e     - FSM state encodings LsuIdle / LsuReq / LsuWait
//   MemB..MemHU     - funct3 access-size codes
//   mem_size()      - maps funct3 to an access width; unlisted codes act as word
package lsu_pkg;

  localparam int RegBus = 32;

  localparam logic Assert   = 1'b1;
  localparam logic Asserted = 1'b1;

  typedef enum logic [1:0] {
    LsuIdle = 2'd0,
    LsuReq  = 2'd1,
    LsuWait = 2'd2
  } lsu_state_e;

  localparam logic [2:0] MemB  = 3'b000;
  localparam logic [2:0] MemH  = 3'b001;
  localparam logic [2:0] MemW  = 3'b010;
  localparam logic [2:0] MemBU = 3'b100;
  localparam logic [2:0] MemHU = 3'b101;

  typedef enum logic [1:0] {
    SzByte = 2'd0,
    SzHalf = 2'd1,
    SzWord = 2'd2
  } mem_size_e;

  function automatic mem_size_e mem_size(input logic [2:0] funct3);
    case (funct3)
      MemB, MemBU: return SzByte;
      MemH, MemHU: return SzHalf;
      default:     return SzWord;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit.
// Ports:
//   st_funct3, st_off, st_data -> be, wdata : byte enables and replicated
//                                             store data for a request
//   ld_funct3, ld_off, rdata   -> ldata     : selected and sign/zero-extended
//                                             load data
// Offsets arriving here are already forced to the access's natural alignment.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        st_funct3,
  input  logic [1:0]        st_off,
  input  logic [RegBus-1:0] st_data,
  output logic [3:0]        be,
  output logic [RegBus-1:0] wdata,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_off,
  input  logic [RegBus-1:0] rdata,
  output logic [RegBus-1:0] ldata
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be    = 4'b1111;
    wdata = st_data;
    case (mem_size(st_funct3))
      SzByte: begin
        be    = 4'b0001 << st_off;
        wdata = {4{st_data[7:0]}};
      end
      SzHalf: begin
        be    = 4'b0011 << st_off;
        wdata = {2{st_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = st_data;
      end
    endcase
  end

  assign ld_byte = rdata[{ld_off, 3'b000} +: 8];
  assign ld_half = rdata[{ld_off[1], 4'b0000} +: 16];

  always_comb begin
    ldata = rdata;
    case (ld_funct3)
      MemB:    ldata = {{24{ld_byte[7]}}, ld_byte};
      MemBU:   ldata = {24'h0, ld_byte};
      MemH:    ldata = {{16{ld_half[15]}}, ld_half};
      MemHU:   ldata = {16'h0, ld_half};
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: memory-stage load/store unit. Accepts one instruction per handshake,
// runs the dmem request/grant/response protocol and hands aligned, extended
// load data (or the pass-through ALU result) to writeback.
// Ports:
//   clk, rst (async, active-high)
//   in_valid_i / in_ready_o            - handshake from execute
//   ctrl_mem_read_i, ctrl_mem_write_i  - load / store (neither = pass-through)
//   ctrl_wb_Mem2Reg_i, funct3_i, alu_result_i, store_data_i
//   dmem_req_o/gnt_i/we_o/addr_o/be_o/wdata_o, dmem_rvalid_i/rdata_i
//   wb_valid_o, mem_read_data_o, alu_result_o, ctrl_wb_Mem2Reg_o, misalign_o
// Build option: LSU_MISALIGN_TRAP_EN - misaligned H/W accesses trap instead
// of being silently realigned.
//
// state   | meaning
// --------+----------------------------------------------------------
// LsuIdle | ready for a new instruction; pass-through/trap finish here
// LsuReq  | dmem_req_o high, request fields held until dmem_gnt_i
// LsuWait | load granted, waiting for dmem_rvalid_i
module lsu
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              ctrl_mem_read_i,
  input  logic              ctrl_mem_write_i,
  input  logic              ctrl_wb_Mem2Reg_i,
  input  logic [2:0]        funct3_i,
  input  logic [RegBus-1:0] alu_result_i,
  input  logic [RegBus-1:0] store_data_i,
  output logic              dmem_req_o,
  input  logic              dmem_gnt_i,
  output logic              dmem_we_o,
  output logic [RegBus-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [RegBus-1:0] dmem_wdata_o,
  input  logic              dmem_rvalid_i,
  input  logic [RegBus-1:0] dmem_rdata_i,
  output logic              wb_valid_o,
  output logic [RegBus-1:0] mem_read_data_o,
  output logic [RegBus-1:0] alu_result_o,
  output logic              ctrl_wb_Mem2Reg_o,
  output logic              misalign_o
);

  lsu_state_e        state;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [1:0]        off_in;
  logic [1:0]        eff_off;
  logic              is_mem;
  logic              trap;
  logic [3:0]        be_nxt;
  logic [RegBus-1:0] wdata_nxt;
  logic [RegBus-1:0] ldata;

  assign off_in = alu_result_i[1:0];
  assign is_mem = ctrl_mem_read_i | ctrl_mem_write_i;

  // Natural alignment of the access; a misaligned request is the one whose
  // raw offset differs from it.
  always_comb begin
    eff_off = off_in;
    case (mem_size(funct3_i))
      SzHalf:  eff_off = {off_in[1], 1'b0};
      SzWord:  eff_off = 2'b00;
      default: eff_off = off_in;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_mem & (off_in != eff_off);
`else
  assign trap = 1'b0;
`endif

  // Store side steered from the incoming instruction (registered on accept);
  // load side from the latched size/offset against the live response bus.
  lsu_align u_align (
    .st_funct3 (funct3_i),
    .st_off    (eff_off),
    .st_data   (store_data_i),
    .be        (be_nxt),
    .wdata     (wdata_nxt),
    .ld_funct3 (funct3_q),
    .ld_off    (off_q),
    .rdata     (dmem_rdata_i),
    .ldata     (ldata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= LsuIdle;
      funct3_q          <= 3'b000;
      off_q             <= 2'b00;
      in_ready_o        <= 1'b1;
      dmem_req_o        <= 1'b0;
      dmem_we_o         <= 1'b0;
      dmem_addr_o       <= '0;
      dmem_be_o         <= 4'b0000;
      dmem_wdata_o      <= '0;
      wb_valid_o        <= 1'b0;
      mem_read_data_o   <= '0;
      alu_result_o      <= '0;
      ctrl_wb_Mem2Reg_o <= 1'b0;
      misalign_o        <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      case (state)
        LsuIdle: begin
          if (in_valid_i) begin
            alu_result_o      <= alu_result_i;
            ctrl_wb_Mem2Reg_o <= ctrl_wb_Mem2Reg_i;
            funct3_q          <= funct3_i;
            off_q             <= eff_off;
            if (trap) begin
              wb_valid_o      <= 1'b1;
              misalign_o      <= 1'b1;
              mem_read_data_o <= '0;
            end else if (is_mem) begin
              state        <= LsuReq;
              in_ready_o   <= 1'b0;
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= ~ctrl_mem_read_i;
              dmem_addr_o  <= {alu_result_i[RegBus-1:2], 2'b00};
              dmem_be_o    <= be_nxt;
              dmem_wdata_o <= wdata_nxt;
              // A load keeps the previous result visible until its own data lands.
              if (!ctrl_mem_read_i) begin
                mem_read_data_o <= '0;
              end
            end else begin
              wb_valid_o      <= 1'b1;
              mem_read_data_o <= '0;
            end
          end
        end
        LsuReq: begin
          if (dmem_gnt_i) begin
            dmem_req_o <= 1'b0;
            if (dmem_we_o) begin
              state      <= LsuIdle;
              in_ready_o <= 1'b1;
              wb_valid_o <= 1'b1;
            end else begin
              state <= LsuWait;
            end
          end
        end
        LsuWait: begin
          if (dmem_rvalid_i) begin
            state           <= LsuIdle;
            in_ready_o      <= 1'b1;
            wb_valid_o      <= 1'b1;
            mem_read_data_o <= ldata;
          end
        end
        default: begin
          state      <= LsuIdle;
          in_ready_o <= 1'b1;
          dmem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed plus randomized bench for lsu. Expected bus fields and
// load results come from a byte-level reference model of the access rules.
// Build option: LSU_MISALIGN_TRAP_EN selects the trapping expectations.
module tb_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        ctrl_mem_read_i;
  logic        ctrl_mem_write_i;
  logic        ctrl_wb_Mem2Reg_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_result_i;
  logic [31:0] store_data_i;
  logic        dmem_req_o;
  logic        dmem_gnt_i;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [31:0] mem_read_data_o;
  logic [31:0] alu_result_o;
  logic        ctrl_wb_Mem2Reg_o;
  logic        misalign_o;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_mrd  = 32'h0;

  lsu dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid_i        (in_valid_i),
    .in_ready_o        (in_ready_o),
    .ctrl_mem_read_i   (ctrl_mem_read_i),
    .ctrl_mem_write_i  (ctrl_mem_write_i),
    .ctrl_wb_Mem2Reg_i (ctrl_wb_Mem2Reg_i),
    .funct3_i          (funct3_i),
    .alu_result_i      (alu_result_i),
    .store_data_i      (store_data_i),
    .dmem_req_o        (dmem_req_o),
    .dmem_gnt_i        (dmem_gnt_i),
    .dmem_we_o         (dmem_we_o),
    .dmem_addr_o       (dmem_addr_o),
    .dmem_be_o         (dmem_be_o),
    .dmem_wdata_o      (dmem_wdata_o),
    .dmem_rvalid_i     (dmem_rvalid_i),
    .dmem_rdata_i      (dmem_rdata_i),
    .wb_valid_o        (wb_valid_o),
    .mem_read_data_o   (mem_read_data_o),
    .alu_result_o      (alu_result_o),
    .ctrl_wb_Mem2Reg_o (ctrl_wb_Mem2Reg_o),
    .misalign_o        (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned ref_bytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return ((a % 4) % ref_bytes(f3)) != 0;
  endfunction

  // Offset actually used: rounded down to the access size.
  function automatic int unsigned ref_off(input logic [2:0] f3, input logic [31:0] a);
    return ((a % 4) / ref_bytes(f3)) * ref_bytes(f3);
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned v;
    v = ((1 << ref_bytes(f3)) - 1) << ref_off(f3, a);
    return v[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (ref_bytes(f3))
      1:       return (sd % 256) * 32'h0101_0101;
      2:       return (sd % 65536) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] mask;
    logic [31:0] v;
    int unsigned nb;
    nb   = ref_bytes(f3);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    v    = (rd >> (8 * ref_off(f3, a))) & mask;
    if ((f3 == 3'b000 || f3 == 3'b001) && v > (mask >> 1)) v = v | ~mask;
    return v;
  endfunction

  // kind: 0 pass-through, 1 load, 2 store. gd/rd: extra grant/rvalid wait cycles.
  task automatic do_op(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sd, input logic m2r, input int gd, input int rd,
                       input logic [31:0] rdata, input bit early_rv);
    bit trapped;
    trapped = (kind != 0) && TRAP && ref_misaligned(f3, addr);
    chk("ready_before_accept", in_ready_o, 1);
    in_valid_i        = 1'b1;
    ctrl_mem_read_i   = (kind == 1);
    ctrl_mem_write_i  = (kind == 2);
    ctrl_wb_Mem2Reg_i = m2r;
    funct3_i          = f3;
    alu_result_i      = addr;
    store_data_i      = sd;
    @(posedge clk); #1;
    in_valid_i       = 1'b0;
    ctrl_mem_read_i  = 1'($urandom);
    ctrl_mem_write_i = 1'($urandom);
    alu_result_i     = $urandom;
    chk("alu_result_o", alu_result_o, addr);
    chk("mem2reg_o", ctrl_wb_Mem2Reg_o, m2r);
    if (kind == 0 || trapped) begin
      chk("wb_valid_n1", wb_valid_o, 1);
      chk("misalign_n1", misalign_o, trapped);
      chk("no_req", dmem_req_o, 0);
      chk("mrd_zero", mem_read_data_o, 0);
      chk("ready_n1", in_ready_o, 1);
      exp_mrd = 32'h0;
      return;
    end
    for (int c = 0; c <= gd; c++) begin
      chk("req_high", dmem_req_o, 1);
      chk("ready_low_req", in_ready_o, 0);
      chk("wb_low_req", wb_valid_o, 0);
      chk("misalign_low", misalign_o, 0);
      chk("addr", dmem_addr_o, {addr[31:2], 2'b00});
      chk("we", dmem_we_o, (kind == 2));
      chk("be", dmem_be_o, ref_be(f3, addr));
      if (kind == 2) chk("wdata", dmem_wdata_o, ref_wdata(f3, sd));
      dmem_gnt_i    = (c == gd);
      dmem_rvalid_i = early_rv && (c != gd);
      dmem_rdata_i  = ~rdata;
      @(posedge clk); #1;
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
    end
    if (kind == 2) begin
      chk("st_wb_valid", wb_valid_o, 1);
      chk("st_ready", in_ready_o, 1);
      chk("st_req_low", dmem_req_o, 0);
      chk("st_mrd_zero", mem_read_data_o, 0);
      exp_mrd = 32'h0;
      return;
    end
    for (int c = 0; c <= rd; c++) begin
      chk("wait_req_low", dmem_req_o, 0);
      chk("wait_wb_low", wb_valid_o, 0);
      chk("wait_ready_low", in_ready_o, 0);
      chk("mrd_hold", mem_read_data_o, exp_mrd);
      dmem_rvalid_i = (c == rd);
      dmem_rdata_i  = (c == rd) ? rdata : $urandom;
      @(posedge clk); #1;
      dmem_rvalid_i = 1'b0;
    end
    exp_mrd = ref_load(f3, addr, rdata);
    chk("ld_wb_valid", wb_valid_o, 1);
    chk("ld_data", mem_read_data_o, exp_mrd);
    chk("ld_ready", in_ready_o, 1);
    chk("ld_misalign_low", misalign_o, 0);
  endtask

  initial begin
    rst               = 1'b1;
    in_valid_i        = 1'b0;
    ctrl_mem_read_i   = 1'b0;
    ctrl_mem_write_i  = 1'b0;
    ctrl_wb_Mem2Reg_i = 1'b0;
    funct3_i          = 3'b000;
    alu_result_i      = 32'h0;
    store_data_i      = 32'h0;
    dmem_gnt_i        = 1'b0;
    dmem_rvalid_i     = 1'b0;
    dmem_rdata_i      = 32'h0;
    #2;
    chk("rst_ready", in_ready_o, 1);
    chk("rst_req", dmem_req_o, 0);
    chk("rst_wb", wb_valid_o, 0);
    chk("rst_mrd", mem_read_data_o, 0);
    chk("rst_alu", alu_result_o, 0);
    chk("rst_be", dmem_be_o, 0);
    chk("rst_addr", dmem_addr_o, 0);
    chk("rst_misalign", misalign_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Pass-through.
    do_op(0, 3'b000, 32'h0000_1234, 32'h0, 1'b0, 0, 0, 32'h0, 1'b0);
    chk("pt_alu_lit", alu_result_o, 32'h0000_1234);
    // SB at 0x1003, grant two cycles late.
    do_op(2, 3'b000, 32'h0000_1003, 32'h0000_00AB, 1'b0, 2, 0, 32'h0, 1'b0);
    // Loads with literal expectations.
    do_op(1, 3'b000, 32'h0000_2001, 32'h0, 1'b1, 0, 0, 32'h0000_8000, 1'b0);
    chk("lb_lit", mem_read_data_o, 32'hFFFF_FF80);
    do_op(1, 3'b100, 32'h0000_2001, 32'h0, 1'b1, 0, 0, 32'h0000_8000, 1'b0);
    chk("lbu_lit", mem_read_data_o, 32'h0000_0080);
    do_op(1, 3'b101, 32'h0000_2002, 32'h0, 1'b1, 0, 0, 32'hBEEF_0000, 1'b0);
    chk("lhu_lit", mem_read_data_o, 32'h0000_BEEF);
    do_op(1, 3'b001, 32'h0000_2002, 32'h0, 1'b1, 1, 1, 32'hBEEF_0000, 1'b1);
    chk("lh_lit", mem_read_data_o, 32'hFFFF_BEEF);
    // LW: grant at once, rvalid four cycles into WAIT; then with stray rvalid in REQ.
    do_op(1, 3'b010, 32'h0000_2004, 32'h0, 1'b1, 0, 3, 32'hCAFE_F00D, 1'b0);
    chk("lw_lit", mem_read_data_o, 32'hCAFE_F00D);
    do_op(1, 3'b010, 32'h0000_2008, 32'h0, 1'b1, 2, 0, 32'h1357_9BDF, 1'b1);
    // Misaligned LW at 0x3002.
    do_op(1, 3'b010, 32'h0000_3002, 32'h0, 1'b1, 0, 0, 32'h2468_ACE0, 1'b0);

    // Reset while waiting for rvalid.
    in_valid_i = 1'b1; ctrl_mem_read_i = 1'b1; ctrl_mem_write_i = 1'b0;
    funct3_i = 3'b010; alu_result_i = 32'h0000_4000;
    @(posedge clk); #1;
    in_valid_i = 1'b0; dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0;
    chk("wait_before_rst", in_ready_o, 0);
    rst = 1'b1; #1;
    chk("rst_wait_req", dmem_req_o, 0);
    chk("rst_wait_wb", wb_valid_o, 0);
    chk("rst_wait_ready", in_ready_o, 1);
    #1 rst = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0;
    chk("late_rvalid_wb", wb_valid_o, 0);
    chk("late_rvalid_mrd", mem_read_data_o, 0);
    @(posedge clk); #1;
    chk("late_rvalid_wb2", wb_valid_o, 0);
    exp_mrd = 32'h0;

    // Reset while requesting: req must drop without a clock.
    in_valid_i = 1'b1; ctrl_mem_read_i = 1'b0; ctrl_mem_write_i = 1'b1;
    funct3_i = 3'b010; alu_result_i = 32'h0000_5000;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    chk("req_before_rst", dmem_req_o, 1);
    #1 rst = 1'b1; #1;
    chk("rst_req_drop", dmem_req_o, 0);
    chk("rst_req_ready", in_ready_o, 1);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_wb", wb_valid_o, 0);

    // Randomized traffic, back to back.
    for (int i = 0; i < 150; i++) begin
      do_op(int'($urandom_range(0, 2)), 3'($urandom), $urandom, $urandom, 1'($urandom),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
